// File: rtl/alu_pkg.sv
// Shared constants and types for the sequential ALU: funct3/funct7 encodings and FSM states.
package alu_pkg;

  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative M-extension unit: shift-add multiply and restoring divide over XLEN cycles on
// magnitudes, sign-corrected on the final step; divide-by-zero/overflow reported as fast results.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            fast,
  output logic [XLEN-1:0] fast_result,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned     CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic              is_div, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              active, neg_q, neg_r;
  logic [2:0]        op;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, mcand, acc_n, prod;
  logic [XLEN-1:0]   mplier, quo, rem, dvsr, quo_n, rem_n, quo_f, rem_f;
  logic [XLEN:0]     rem_sh, diff;

  assign is_div   = funct3[2];
  assign a_signed = is_div ? !funct3[0] : (funct3 == F3_MULH || funct3 == F3_MULHSU);
  assign b_signed = is_div ? !funct3[0] : (funct3 == F3_MULH);
  assign a_neg    = a_signed && a[XLEN-1];
  assign b_neg    = b_signed && b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;

  assign div_zero = is_div && (b == '0);
  assign div_ovf  = is_div && !funct3[0] && (a == MOST_NEG) && (b == '1);
  assign fast     = div_zero || div_ovf;

  always_comb begin
    fast_result = '0;
    if (div_zero)     fast_result = funct3[1] ? a : '1;
    else if (div_ovf) fast_result = funct3[1] ? '0 : MOST_NEG;
  end

  // Both datapaths step every cycle; op selects which one forms the result.
  assign acc_n  = acc + (mplier[0] ? mcand : '0);
  assign rem_sh = {rem, quo[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvsr};
  assign rem_n  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_n  = {quo[XLEN-2:0], !diff[XLEN]};

  assign prod   = neg_q ? -acc_n : acc_n;
  assign quo_f  = neg_q ? -quo_n : quo_n;
  assign rem_f  = neg_r ? -rem_n : rem_n;

  always_comb begin
    if (op[2])              result = op[1] ? rem_f : quo_f;
    else if (op == F3_MUL)  result = prod[XLEN-1:0];
    else                    result = prod[2*XLEN-1:XLEN];
  end

  assign done = active && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      cnt    <= '0;
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      quo    <= '0;
      rem    <= '0;
      dvsr   <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      op     <= funct3;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      acc    <= '0;
      mcand  <= {{XLEN{1'b0}}, b_mag};
      mplier <= a_mag;
      quo    <= a_mag;
      rem    <= '0;
      dvsr   <= b_mag;
    end else if (active) begin
      cnt    <= cnt + CNT_W'(1);
      active <= (cnt != LAST);
      acc    <= acc_n;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      quo    <= quo_n;
      rem    <= rem_n;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked RV32I register-register ALU with registered result.
// Define ALU_MULDIV_EN to add the iterative M-extension unit (funct7 0x01).
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            z,
  output logic            illegal
);

  state_t               state;
  logic                 accept, op_ill, op_iter, alt, md_done;
  logic [XLEN-1:0]      op_res, md_result;
  logic [SHAMT_W-1:0]   shamt;

  assign shamt    = rs2[SHAMT_W-1:0];
  assign alt      = (funct7 == F7_ALT);
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_MULDIV_EN
  logic            md_fast;
  logic [XLEN-1:0] md_fast_result;

  alu_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (accept && op_iter),
    .funct3      (funct3),
    .a           (rs1),
    .b           (rs2),
    .fast        (md_fast),
    .fast_result (md_fast_result),
    .done        (md_done),
    .result      (md_result)
  );

  assign op_iter = (funct7 == F7_MULDIV) && !md_fast;
`else
  assign op_iter   = 1'b0;
  assign md_done   = 1'b0;
  assign md_result = '0;
`endif

  always_comb begin
    op_res = '0;
    op_ill = 1'b0;
    if (funct7 == F7_BASE || (alt && (funct3 == F3_ADD || funct3 == F3_SR))) begin
      case (funct3)
        F3_ADD:  op_res = alt ? rs1 - rs2 : rs1 + rs2;
        F3_SLL:  op_res = rs1 << shamt;
        F3_SLT:  op_res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(rs2)};
        F3_SLTU: op_res = {{(XLEN-1){1'b0}}, rs1 < rs2};
        F3_XOR:  op_res = rs1 ^ rs2;
        F3_SR: begin
          // kept as separate statements so the arithmetic shift stays signed
          if (alt) op_res = $signed(rs1) >>> shamt;
          else     op_res = rs1 >> shamt;
        end
        F3_OR:   op_res = rs1 | rs2;
        F3_AND:  op_res = rs1 & rs2;
        default: op_res = '0;
      endcase
    end else if (funct7 == F7_MULDIV) begin
`ifdef ALU_MULDIV_EN
      op_res = md_fast_result;
`else
      op_ill = 1'b1;
`endif
    end else begin
      op_ill = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      rd        <= '0;
      z         <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (op_iter) begin
              state     <= BUSY;
              out_valid <= 1'b0;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              rd        <= op_res;
              z         <= (op_res == '0);
              illegal   <= op_ill;
            end
          end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        BUSY: begin
          if (md_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            rd        <= md_result;
            z         <= (md_result == '0);
            illegal   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: per-cycle monitor against an arithmetic model plus literal vectors.
module tb_alu_seq;

`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic        in_ready, out_valid, z, illegal;
  logic [31:0] rd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  alu_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd        (rd),
    .z         (z),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Returns {illegal, rd} from the ISA definition of each operation.
  function automatic logic [32:0] model(input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        ill;
    int          sa, sb;
    longint      sp;
    logic [63:0] up;
    r = '0; ill = 1'b0; sa = a; sb = b;
    if (f7 == 7'h00) begin
      case (f3)
        3'd0: r = a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = a >> b[4:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else if (f7 == 7'h20 && f3 == 3'd0) r = a - b;
    else if (f7 == 7'h20 && f3 == 3'd5) r = sa >>> b[4:0];
    else if (f7 == 7'h01 && MD) begin
      case (f3)
        3'd0: r = a * b;
        3'd1: begin sp = longint'(sa) * longint'(sb); r = sp[63:32]; end
        3'd2: begin sp = longint'(sa) * longint'(b);  r = sp[63:32]; end
        3'd3: begin up = {32'd0, a} * {32'd0, b};      r = up[63:32]; end
        3'd4: if (b == 0) r = '1; else if (a == 32'h8000_0000 && b == '1) r = a; else r = sa / sb;
        3'd5: r = (b == 0) ? '1 : a / b;
        3'd6: if (b == 0) r = a; else if (a == 32'h8000_0000 && b == '1) r = '0; else r = sa % sb;
        default: r = (b == 0) ? a : a % b;
      endcase
    end else ill = 1'b1;
    return {ill, r};
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] a, input logic [31:0] b);
    if (MD && f7 == 7'h01 &&
        !(f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == '1))))
      return 33;
    return 1;
  endfunction

  // Per-cycle monitor: at most one outstanding result, due at a known cycle.
  logic        pend = 1'b0;
  int          pend_t = 0;
  logic [31:0] pend_rd = '0;
  logic        pend_ill = 1'b0;

  always @(negedge clk) begin
    logic        due;
    logic [32:0] m;
    if (!rst_n) pend = 1'b0;
    else begin
      due = pend && (cyc >= pend_t);
      chk("mon out_valid", out_valid, due);
      if (due) begin
        chk("mon rd", rd, pend_rd);
        chk("mon z", z, pend_rd == 0);
        chk("mon illegal", illegal, pend_ill);
      end
      chk("mon in_ready", in_ready, !pend || (due && out_ready));
      if (due && out_ready) pend = 1'b0;
      if (in_valid && in_ready) begin
        m        = model(funct3, funct7, rs1, rs2);
        pend     = 1'b1;
        pend_t   = cyc + model_lat(funct3, funct7, rs1, rs2);
        pend_rd  = m[31:0];
        pend_ill = m[32];
      end
    end
  end

  // Caller is at posedge+#1; returns at posedge+#1 just after the accept edge.
  task automatic drive(input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_valid = 1'b1; funct3 = f3; funct7 = f7; rs1 = a; rs2 = b;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept timeout: in_ready stuck low for %0d cycles", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string name, input logic [31:0] erd,
                               input logic eill, input int elat);
    int lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 200);
    chk({name, " latency"}, lat, elat);
    chk({name, " rd"}, rd, erd);
    chk({name, " illegal"}, illegal, eill);
    chk({name, " z"}, z, erd == 0);
  endtask

  task automatic run(input string name, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] erd, input logic eill, input int elat);
    @(posedge clk); #1;
    drive(f3, f7, a, b);
    expect_result(name, erd, eill, elat);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset rd", rd, 0);
    chk("reset z", z, 0);
    chk("reset illegal", illegal, 0);
    chk("reset in_ready", in_ready, 1);

    run("add",      3'b000, 7'h00, 32'd20,        32'd30,        32'd50,        0, 1);
    run("sub",      3'b000, 7'h20, 32'd8,         32'd3,         32'd5,         0, 1);
    run("sub zero", 3'b000, 7'h20, 32'd5,         32'd5,         32'd0,         0, 1);
    run("alt or",   3'b110, 7'h20, 32'd7,         32'd9,         32'd0,         1, 1);
    run("sra",      3'b101, 7'h20, 32'h8000_0000, 32'd4,         32'hF800_0000, 0, 1);
    run("sll",      3'b001, 7'h00, 32'd1,         32'd35,        32'd8,         0, 1);
    run("slt",      3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1,         32'd1,         0, 1);
    run("sltu",     3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1,         32'd0,         0, 1);
    run("srl",      3'b101, 7'h00, 32'h8000_0000, 32'd36,        32'h0800_0000, 0, 1);
    run("xor",      3'b100, 7'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 1);
    run("or",       3'b110, 7'h00, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 0, 1);
    run("and",      3'b111, 7'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 1);
    run("add wrap", 3'b000, 7'h00, 32'hFFFF_FFFF, 32'd1,         32'd0,         0, 1);
    run("f7 7f",    3'b000, 7'h7F, 32'd1,         32'd2,         32'd0,         1, 1);
    run("alt sll",  3'b001, 7'h20, 32'd1,         32'd2,         32'd0,         1, 1);

`ifdef ALU_MULDIV_EN
    run("mul",      3'b000, 7'h01, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 33);
    run("div by 0", 3'b100, 7'h01, 32'd7,         32'd0,         32'hFFFF_FFFF, 0, 1);
    run("div ovf",  3'b100, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1);
    run("rem ovf",  3'b110, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0, 1);
    run("remu by0", 3'b111, 7'h01, 32'd5,         32'd0,         32'd5,         0, 1);
    run("remu",     3'b111, 7'h01, 32'd10,        32'd3,         32'd1,         0, 33);
    run("div neg",  3'b100, 7'h01, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, 33);
    run("rem neg",  3'b110, 7'h01, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0, 33);
    run("mulhu",    3'b011, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 33);
    run("mulh",     3'b001, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         0, 33);
    run("mulhsu",   3'b010, 7'h01, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 0, 33);
    run("divu",     3'b101, 7'h01, 32'd100,       32'd7,         32'd14,        0, 33);
`else
    run("m off",    3'b000, 7'h01, 32'd7,         32'hFFFF_FFFD, 32'd0,         1, 1);
    run("m off div",3'b100, 7'h01, 32'd7,         32'd0,         32'd0,         1, 1);
`endif

    // Backpressure hold, then back-to-back accept as the held result drains.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(3'b000, 7'h00, 32'h11, 32'h22);
    expect_result("bp", 32'h33, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp hold rd", rd, 32'h33);
      chk("bp hold z", z, 0);
      chk("bp hold out_valid", out_valid, 1);
      chk("bp hold in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; funct3 = 3'b000; funct7 = 7'h20; rs1 = 32'h40; rs2 = 32'h10;
    @(negedge clk);
    chk("b2b in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_result("b2b", 32'h30, 0, 1);

    // Streaming: one accept per cycle with out_ready high.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      funct3 = 3'(i * 3); funct7 = 7'h00;
      rs1 = 32'h1234_5678 + 32'(i); rs2 = 32'd3 + 32'(i);
      @(negedge clk);
      chk("tput in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of an operation discards it.
    @(posedge clk); #1;
`ifdef ALU_MULDIV_EN
    drive(3'b000, 7'h01, 32'd7, 32'd9);
`else
    out_ready = 1'b0;
    drive(3'b000, 7'h00, 32'd7, 32'd9);
`endif
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst abort out_valid", out_valid, 0);
    chk("rst abort rd", rd, 0);
    chk("rst abort in_ready", in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst no stale result", seen, 0);

    run("post rst", 3'b000, 7'h00, 32'd1, 32'd2, 32'd3, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the core's single-cycle ALU. It executes the RV32I register-register integer operations selected by funct3/funct7 at a configurable data width, with a registered result and a valid/ready interface on both sides. Optionally, it executes the RV M-extension operations as a multi-cycle iterative unit. It sits in the execute stage between the register-read stage and writeback.

## Interface
- XLEN, 32: datapath width; must be a power of two, at least 8.
- SHAMT_W, $clog2(XLEN): shift-amount width (derived; do not override).
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation.
- rs1  in  XLEN  operand A.
- rs2  in  XLEN  operand B.
- funct3  in  3  operation select.
- funct7  in  7  operation modifier: 0x00 base, 0x20 SUB/SRA, 0x01 M-extension.
- out_valid  out  1  result held in rd.
- out_ready  in  1  consumer takes the result.
- rd  out  XLEN  result.
- z  out  1  high when rd is zero.
- illegal  out  1  unsupported funct3/funct7 combination; rd is 0 in that case.

## Operation
- Transfer rules:
  - An input transfer occurs when in_valid and in_ready are both high.
  - An output transfer occurs when out_valid and out_ready are both high.
- States:
  - IDLE: in_ready=1.
  - BUSY: iterating; in_ready=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Transitions:
  - IDLE -> DONE on accept of a single-cycle op.
  - IDLE -> BUSY on accept of an iterative M op.
  - BUSY -> DONE when the iteration counter reaches XLEN-1.
  - DONE -> IDLE on an output transfer with no new accept.
  - DONE -> DONE/BUSY when an output transfer and a new accept happen in the same cycle (back-to-back).
- Base ops, funct3 000..111 (single-cycle): ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
  - funct7 0x20 is legal only with funct3 000 and 101.
  - Any other funct7 value sets illegal=1.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN.
  - Shifts use rs2[SHAMT_W-1:0] only; upper bits are ignored.
  - SLT compares signed; SLTU compares unsigned; result is 0 or 1, zero-extended.
- rd, z and illegal are registered and stay stable while out_valid=1 and out_ready=0.
- Reset values: out_valid=0, rd=0, z=0, illegal=0, state=IDLE. The block comes out of reset with in_ready=1.
- Reset asserted mid-operation aborts the operation; no result is produced.

## Timing
- Single-cycle op accepted in cycle N: out_valid is high in cycle N+1.
- Iterative M op accepted in cycle N: out_valid is high in cycle N+XLEN+1.
- M-op fast paths complete in N+1, with RISC-V semantics:
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return rs1.
  - Signed overflow (most-negative / -1): DIV returns most-negative; REM returns 0.
- Throughput: one single-cycle op per cycle when out_ready is held high.
- in_ready depends combinationally on out_ready in DONE only.

## Configuration
- ALU_MULDIV_EN defined:
  - funct7 0x01 selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU by funct3.
  - Multiply uses an iterative shift-add; divide uses iterative restoring division; each takes XLEN cycles.
  - Signs are corrected at the final step.
- ALU_MULDIV_EN undefined:
  - funct7 0x01 gives illegal=1 and rd=0 with single-cycle latency.
  - The BUSY state is unreachable.

## Structure
- Package alu_pkg holds:
  - the funct3 operation constants;
  - the funct7 constants (F7_BASE, F7_ALT, F7_MULDIV);
  - the state enum (IDLE, BUSY, DONE).
- Sub-module alu_muldiv contains the iterative multiply/divide datapath, its counter and the fast-path detection. It has a start/done interface and is instantiated only under ALU_MULDIV_EN.

## Test plan
- ADD rs1=20, rs2=30, out_ready=1 -> rd=50, z=0, out_valid exactly one cycle after accept.
- SUB 8-3 -> rd=5. Then SUB 5-5 -> rd=0, z=1. Then funct7=0x20 with funct3=110 -> illegal=1, rd=0.
- SRA 0x80000000 by 4 -> rd=0xF8000000. SLL 1 with rs2=35 -> rd=8. SLT rs1=0xFFFFFFFF, rs2=1 -> rd=1. SLTU with the same operands -> rd=0.
- Backpressure: out_ready held low 3 cycles after the result -> rd/z stable and in_ready=0. Then out_ready=1 with in_valid=1 -> back-to-back accept in the same cycle.
- ALU_MULDIV_EN: MUL 7 × 0xFFFFFFFD -> rd=0xFFFFFFEB at N+33. DIV 7/0 -> rd=0xFFFFFFFF at N+1. DIV 0x80000000/0xFFFFFFFF -> rd=0x80000000. REMU 10/3 -> rd=1.
- Reset: rst_n pulsed low during BUSY at cycle N+10 -> out_valid=0, rd=0, in_ready=1 after release, and no stale result appears.
